// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
// Combinational helpers only, so no latency and no backpressure.
package mem_arb_pkg;

    localparam logic REQ_I   = 1'b0;
    localparam logic REQ_D   = 1'b1;
    localparam int   BANK_HI = 2;
    localparam int   BANK_LO = 1;

    typedef enum logic {
        PRI_I = 1'b0,
        PRI_D = 1'b1
    } pri_state_t;

    // One return-pipeline slot: whether a read is in flight and who owns it.
    typedef struct packed {
        logic vld;
        logic owner;
    } ret_ent_t;

    function automatic logic [1:0] bank_of(input logic [15:0] addr);
        return addr[BANK_HI:BANK_LO];
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundles both requester ports and the shared memory port of the arbiter.
// Wires only, so no latency; requests are held by the requester until granted.
interface mem_port_arbiter_if;

    logic        i_req,    d_req;
    logic        i_wr,     d_wr;
    logic [15:0] i_addr,   d_addr;
    logic [15:0] i_wdata,  d_wdata;
    logic        i_gnt,    d_gnt;
    logic        i_rvalid, d_rvalid;
    logic [15:0] i_rdata,  d_rdata;
    logic        i_err,    d_err;

    logic [15:0] m_addr;
    logic [15:0] m_data_in;
    logic        m_wr;
    logic        m_rd;
    logic [15:0] m_data_out;
    logic        m_stall;
    logic [3:0]  m_busy;
    logic        m_err;

    // slave is the arbiter's view; master is the caches plus memory around it.
    modport slave (
        input  i_req, d_req, i_wr, d_wr, i_addr, d_addr, i_wdata, d_wdata,
        input  m_data_out, m_stall, m_busy, m_err,
        output i_gnt, d_gnt, i_rvalid, d_rvalid, i_rdata, d_rdata, i_err, d_err,
        output m_addr, m_data_in, m_wr, m_rd
    );

    modport master (
        output i_req, d_req, i_wr, d_wr, i_addr, d_addr, i_wdata, d_wdata,
        output m_data_out, m_stall, m_busy, m_err,
        input  i_gnt, d_gnt, i_rvalid, d_rvalid, i_rdata, d_rdata, i_err, d_err,
        input  m_addr, m_data_in, m_wr, m_rd
    );

endinterface

// File: rtl/arb_ret_pipe.sv
// Fixed-depth shift register of {valid, owner} tags for in-flight reads.
// DEPTH cycles from push to tail; never stalls, one push per cycle.
module arb_ret_pipe
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic     clk,
    input  logic     rst,
    input  ret_ent_t i_push,
    output ret_ent_t o_tail
);

    ret_ent_t [DEPTH:0] w_stage;

    assign w_stage[0] = i_push;

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        dff #(.W($bits(ret_ent_t))) u_dff (
            .clk (clk),
            .rst (rst),
            .i_d (w_stage[g]),
            .o_q (w_stage[g+1])
        );
    end

    assign o_tail = w_stage[DEPTH];

endmodule

// File: rtl/dff.sv
// Generic register cell with asynchronous active-high reset.
// One cycle latency; no backpressure.
module dff #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) o_q <= RST_VAL;
        else     o_q <= i_d;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates icache/dcache onto one memory port: 0-cycle grant, reads return after RD_LAT.
// Blocked requesters hold req; MAX_WAIT forces a win. ARB_DCACHE_PRI_EN pins ties to dcache.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int RD_LAT   = 2,
    parameter int MAX_WAIT = 7
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.slave  bus
);

    localparam logic [3:0] MAX_W = 4'(MAX_WAIT);
`ifdef ARB_DCACHE_PRI_EN
    localparam pri_state_t PRI_RST = PRI_D;
`else
    localparam pri_state_t PRI_RST = PRI_I;
`endif

    pri_state_t  r_pri_state, w_pri_next;
    logic [3:0]  r_i_wait, r_d_wait, w_i_wait_nxt, w_d_wait_nxt;
    logic        w_i_elig, w_d_elig, w_i_force, w_d_force;
    logic        w_issue, w_winner, w_sel_wr;
    logic        w_i_ret, w_d_ret;
    ret_ent_t    w_push, w_tail;

    assign w_i_elig  = bus.i_req & ~bus.m_stall & ~bus.m_busy[bank_of(bus.i_addr)];
    assign w_d_elig  = bus.d_req & ~bus.m_stall & ~bus.m_busy[bank_of(bus.d_addr)];
    assign w_i_force = w_i_elig & (r_i_wait == MAX_W);
    assign w_d_force = w_d_elig & (r_d_wait == MAX_W);

    // A lone starving requester overrides priority; two starving ones fall back to it.
    always_comb begin
        w_issue  = 1'b0;
        w_winner = REQ_I;
        if (!rst) begin
            if (w_i_force && !w_d_force) begin
                w_issue  = 1'b1;
                w_winner = REQ_I;
            end else if (w_d_force && !w_i_force) begin
                w_issue  = 1'b1;
                w_winner = REQ_D;
            end else if (w_i_elig && w_d_elig) begin
                w_issue  = 1'b1;
                w_winner = (r_pri_state == PRI_D) ? REQ_D : REQ_I;
            end else if (w_i_elig) begin
                w_issue  = 1'b1;
                w_winner = REQ_I;
            end else if (w_d_elig) begin
                w_issue  = 1'b1;
                w_winner = REQ_D;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_pri_state <= PRI_RST;
        else     r_pri_state <= w_pri_next;
    end

    always_comb begin
        w_pri_next = r_pri_state;
`ifdef ARB_DCACHE_PRI_EN
        w_pri_next = PRI_D;
`else
        if (w_issue) w_pri_next = (w_winner == REQ_I) ? PRI_D : PRI_I;
`endif
    end

    always_comb begin
        w_i_wait_nxt = 4'd0;
        w_d_wait_nxt = 4'd0;
        if (bus.i_req && !(w_issue && w_winner == REQ_I))
            w_i_wait_nxt = (r_i_wait == MAX_W) ? r_i_wait : r_i_wait + 4'd1;
        if (bus.d_req && !(w_issue && w_winner == REQ_D))
            w_d_wait_nxt = (r_d_wait == MAX_W) ? r_d_wait : r_d_wait + 4'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_i_wait <= 4'd0;
            r_d_wait <= 4'd0;
        end else begin
            r_i_wait <= w_i_wait_nxt;
            r_d_wait <= w_d_wait_nxt;
        end
    end

    assign w_sel_wr      = (w_winner == REQ_D) ? bus.d_wr : bus.i_wr;
    assign bus.i_gnt     = w_issue & (w_winner == REQ_I);
    assign bus.d_gnt     = w_issue & (w_winner == REQ_D);
    assign bus.m_addr    = !w_issue ? 16'd0 : (w_winner == REQ_D) ? bus.d_addr  : bus.i_addr;
    assign bus.m_data_in = !w_issue ? 16'd0 : (w_winner == REQ_D) ? bus.d_wdata : bus.i_wdata;
    assign bus.m_wr      = w_issue &  w_sel_wr;
    assign bus.m_rd      = w_issue & ~w_sel_wr;

    assign w_push = '{vld: w_issue & ~w_sel_wr, owner: w_winner};

    arb_ret_pipe #(.DEPTH(RD_LAT)) u_ret_pipe (
        .clk    (clk),
        .rst    (rst),
        .i_push (w_push),
        .o_tail (w_tail)
    );

    assign w_i_ret      = w_tail.vld & (w_tail.owner == REQ_I);
    assign w_d_ret      = w_tail.vld & (w_tail.owner == REQ_D);
    assign bus.i_rvalid = w_i_ret;
    assign bus.d_rvalid = w_d_ret;
    assign bus.i_rdata  = w_i_ret ? bus.m_data_out : 16'd0;
    assign bus.d_rdata  = w_d_ret ? bus.m_data_out : 16'd0;
    // An error in a cycle that both issues and returns pulses both owners.
    assign bus.i_err    = bus.m_err & (bus.i_gnt | w_i_ret);
    assign bus.d_err    = bus.m_err & (bus.d_gnt | w_d_ret);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised plus directed bench for mem_port_arbiter against a cycle-level reference model.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int RD_LAT   = 2;
    localparam int MAX_WAIT = 7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if bus();

    mem_port_arbiter #(.RD_LAT(RD_LAT), .MAX_WAIT(MAX_WAIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Stimulus state: each requester holds its request until the model says it was granted.
    logic        rq [2];
    logic        wr_v [2];
    logic [15:0] ad [2];
    logic [15:0] wd [2];
    logic        stall, merr, in_rst;
    logic [3:0]  busy;
    logic [15:0] dout;

    // Reference model: wait counts, who gets the next tie, reads due by cycle number.
    int wcnt [2];
    int favour;
    int ret_at [int];
    int cyc = 0;

    function automatic int reset_favour();
`ifdef ARB_DCACHE_PRI_EN
        return 1;
`else
        return 0;
`endif
    endfunction

    task automatic cycle();
        int win, rown;
        bit elig [2];
        bit frc [2];
        logic [35:0] e_iss, e_ret, o_iss, o_ret;
        logic [15:0] e_addr, e_wd, e_ird, e_drd;
        logic        e_rd, e_wr;
        logic [1:0]  e_rv, e_er;

        @(negedge clk);
        rst         = in_rst;
        bus.i_req   = rq[0];   bus.d_req   = rq[1];
        bus.i_wr    = wr_v[0]; bus.d_wr    = wr_v[1];
        bus.i_addr  = ad[0];   bus.d_addr  = ad[1];
        bus.i_wdata = wd[0];   bus.d_wdata = wd[1];
        bus.m_stall = stall;   bus.m_busy  = busy;
        bus.m_err   = merr;    bus.m_data_out = dout;
        #2;

        if (in_rst) begin
            wcnt = '{0, 0};
            favour = reset_favour();
            ret_at.delete();
        end

        win = -1;
        if (!in_rst) begin
            for (int r = 0; r < 2; r++) begin
                elig[r] = rq[r] && !stall && !busy[ad[r][2:1]];
                frc[r]  = elig[r] && (wcnt[r] == MAX_WAIT);
            end
            if (frc[0] != frc[1])          win = frc[0] ? 0 : 1;
            else if (elig[0] && elig[1])   win = favour;
            else if (elig[0])              win = 0;
            else if (elig[1])              win = 1;
        end

        rown = -1;
        if (ret_at.exists(cyc)) begin
            rown = ret_at[cyc];
            ret_at.delete(cyc);
        end

        e_addr = (win >= 0) ? ad[win] : 16'd0;
        e_wd   = (win >= 0) ? wd[win] : 16'd0;
        e_wr   = (win >= 0) ? wr_v[win] : 1'b0;
        e_rd   = (win >= 0) ? !wr_v[win] : 1'b0;
        e_rv   = {rown == 1, rown == 0};
        e_ird  = (rown == 0) ? dout : 16'd0;
        e_drd  = (rown == 1) ? dout : 16'd0;
        e_er   = {merr && (win == 1 || rown == 1), merr && (win == 0 || rown == 0)};

        e_iss = {win == 1, win == 0, e_rd, e_wr, e_addr, e_wd};
        e_ret = {e_rv, e_er, e_drd, e_ird};
        o_iss = {bus.d_gnt, bus.i_gnt, bus.m_rd, bus.m_wr, bus.m_addr, bus.m_data_in};
        o_ret = {bus.d_rvalid, bus.i_rvalid, bus.d_err, bus.i_err, bus.d_rdata, bus.i_rdata};
        check($sformatf("issue c%0d", cyc), 64'(o_iss), 64'(e_iss));
        check($sformatf("return c%0d", cyc), 64'(o_ret), 64'(e_ret));

        if (!in_rst) begin
            for (int r = 0; r < 2; r++) begin
                if (rq[r] && win != r) wcnt[r] = (wcnt[r] < MAX_WAIT) ? wcnt[r] + 1 : MAX_WAIT;
                else                   wcnt[r] = 0;
            end
            if (win >= 0) begin
`ifdef ARB_DCACHE_PRI_EN
                favour = 1;
`else
                favour = (win == 0) ? 1 : 0;
`endif
                if (!wr_v[win]) ret_at[cyc + RD_LAT] = win;
                rq[win] = 1'b0;
            end
        end
        cyc++;
    endtask

    task automatic set_req(input int r, input logic w, input logic [15:0] a, input logic [15:0] d);
        rq[r] = 1'b1; wr_v[r] = w; ad[r] = a; wd[r] = d;
    endtask

    task automatic rand_inputs();
        for (int r = 0; r < 2; r++)
            if (!rq[r] && $urandom_range(0, 2) != 0)
                set_req(r, $urandom_range(0, 2) == 0, 16'($urandom), 16'($urandom));
        for (int b = 0; b < 4; b++) busy[b] = ($urandom_range(0, 3) == 0);
        stall = ($urandom_range(0, 9) == 0);
        merr  = ($urandom_range(0, 5) == 0);
        dout  = 16'($urandom);
    endtask

    initial begin
        rq = '{1'b0, 1'b0}; wr_v = '{1'b0, 1'b0};
        ad = '{16'd0, 16'd0}; wd = '{16'd0, 16'd0};
        stall = 1'b0; merr = 1'b0; busy = 4'd0; dout = 16'd0; in_rst = 1'b1;
        wcnt = '{0, 0}; favour = reset_favour();

        repeat (2) cycle();
        in_rst = 1'b0;
        repeat (2) cycle();

        // Single icache read, data returned RD_LAT cycles later.
        set_req(0, 1'b0, 16'h0010, 16'h1234);
        for (int k = 0; k < 4; k++) begin dout = 16'hA000 + 16'(k); cycle(); end

        // Both streaming reads: alternating grants and ordered returns.
        for (int k = 0; k < 10; k++) begin
            if (!rq[0]) set_req(0, 1'b0, 16'h0100 + 16'(k), 16'd0);
            if (!rq[1]) set_req(1, 1'b0, 16'h0200 + 16'(k), 16'd0);
            dout = 16'hB000 + 16'(k);
            cycle();
        end
        rq = '{1'b0, 1'b0};
        repeat (3) cycle();

        // Bank conflict: dcache blocked on bank 1 until it frees.
        set_req(0, 1'b0, 16'h0004, 16'd0);
        set_req(1, 1'b0, 16'h0002, 16'd0);
        busy = 4'b0010;
        repeat (3) cycle();
        busy = 4'b0000;
        repeat (4) cycle();

        // Icache starved on bank 2 while dcache streams writes to bank 0.
        set_req(0, 1'b0, 16'h0004, 16'd0);
        busy = 4'b0100;
        for (int k = 0; k < 10; k++) begin
            if (!rq[1]) set_req(1, 1'b1, 16'h0008, 16'(k));
            cycle();
        end
        busy = 4'b0000;
        if (!rq[1]) set_req(1, 1'b1, 16'h0008, 16'h00FF);
        cycle();
        rq = '{1'b0, 1'b0};
        repeat (3) cycle();

        // Memory error landing on the return of a dcache read.
        set_req(1, 1'b0, 16'h0030, 16'd0);
        cycle();
        cycle();
        merr = 1'b1; dout = 16'hC0DE;
        cycle();
        merr = 1'b0;
        cycle();

        // Reset right after an icache read grant flushes the return.
        set_req(0, 1'b0, 16'h0040, 16'd0);
        merr = 1'b1;
        cycle();
        in_rst = 1'b1;
        cycle();
        in_rst = 1'b0;
        repeat (4) cycle();
        merr = 1'b0;
        check("pri_after_rst", 64'(dut.r_pri_state), 64'(reset_favour()));

        for (int k = 0; k < 3000; k++) begin
            rand_inputs();
            in_rst = (k == 1500 || k == 1501);
            cycle();
        end
        in_rst = 1'b0;
        rq = '{1'b0, 1'b0};
        repeat (RD_LAT + 2) cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single port of the four-bank main memory between the instruction-cache FSM (requester 0) and the data-cache FSM (requester 1) in the direct-mapped cache subsystem. Each cycle it picks at most one requester whose target bank is free and issues its read or write. It routes read data and errors back to the owning requester through a fixed-latency return pipeline. A wait counter guarantees neither cache starves.

## Interface
- RD_LAT, 2: cycles from read issue to valid `m_data_out` (1..4)
- MAX_WAIT, 7: cycles a blocked requester waits before it is forced to win (1..15)
- clk  in  1  clock; one clock domain; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- i_req, d_req  in  1  request; held stable until the matching grant
- i_wr, d_wr  in  1  1 = write, 0 = read
- i_addr, d_addr  in  16  word address; bank = addr[2:1]
- i_wdata, d_wdata  in  16  write data
- i_gnt, d_gnt  out  1  one-cycle pulse: request issued to memory this cycle
- i_rvalid, d_rvalid  out  1  one-cycle pulse: read data valid on *_rdata
- i_rdata, d_rdata  out  16  return data; 0 when *_rvalid is low
- i_err, d_err  out  1  one-cycle error pulse to the owner
- m_addr, m_data_in  out  16  memory address and write data
- m_wr, m_rd  out  1  memory write and read strobes
- m_data_out  in  16  memory read data
- m_stall  in  1  memory cannot accept a request this cycle
- m_busy  in  4  per-bank busy flags
- m_err  in  1  memory error

## Operation
- Requester r is eligible when r_req=1, m_stall=0 and m_busy[r_addr[2:1]]=0.
- FSM `pri_state` has states PRI_I and PRI_D, naming the requester that wins when both are eligible.
  - After an issue, the state moves to favour the other requester (round-robin).
  - Forced override: if a requester's wait_cnt == MAX_WAIT, that requester wins regardless of state.
- Issue is combinational in the same cycle.
  - The winner's gnt is high.
  - m_addr and m_data_in are the winner's signals.
  - m_rd = ~wr and m_wr = wr.
  - With no winner, all memory outputs are 0.
- wait_cnt (4 bits, one per requester):
  - increments while r_req=1 and there is no grant;
  - saturates at MAX_WAIT;
  - clears on grant or when r_req=0.
- Return pipeline is RD_LAT entries of {valid, owner}.
  - A read issue pushes {1, winner}; any other cycle pushes {0, x}.
  - When the tail entry is valid, the owner's rvalid=1 and rdata=m_data_out.
  - Writes produce no return entry.
- Errors:
  - m_err in an issue cycle is routed to the winner's err.
  - m_err in a return cycle is routed to the tail owner.
  - If both apply, both err lines pulse.
  - m_err with neither an issue nor a return is dropped.
- Simultaneous events:
  - Only one issue occurs per cycle, even when the two requesters target different free banks.
  - An issue and a return may occur in the same cycle, to the same or different requesters.

## Timing
- Reset values: pri_state=PRI_I, both wait_cnt=0, pipeline all invalid. All outputs are 0 during and after reset until a request arrives.
- Grant latency is 0 cycles from an eligible request.
- Read data arrives exactly RD_LAT cycles after the grant cycle.
- Back-to-back issues are allowed every cycle. Throughput is one request per cycle when banks are free.
- The requester must not change addr, wr or wdata while req=1 and gnt=0. The arbiter never latches request fields.
- Reset mid-operation flushes the pipeline. Outstanding reads never produce rvalid, and no err pulses follow reset.

## Configuration
- ARB_DCACHE_PRI_EN defined:
  - pri_state is held at PRI_D, so the data cache always wins ties.
  - The MAX_WAIT override for icache remains active as the starvation guard.
- ARB_DCACHE_PRI_EN undefined: round-robin as described in Operation.

## Structure
- Shared package `mem_arb_pkg`:
  - requester ID constants REQ_I=1'b0, REQ_D=1'b1;
  - pri_state encodings PRI_I and PRI_D;
  - bank-field slice constants BANK_HI=2, BANK_LO=1.
- Sub-module `arb_ret_pipe`:
  - an RD_LAT-deep shift register of {valid, owner} using the team's `dff` cells with async reset;
  - outputs the tail entry.
- The top level holds the eligibility logic, the pick logic, the wait counters and the output muxes.

## Test plan
- Icache only, read 0x0010, banks free, RD_LAT=2 -> i_gnt pulses in cycle 0, m_rd=1, m_addr=0x0010. In cycle 2, i_rvalid=1 and i_rdata equals the model value; d_* outputs stay 0.
- Both request in every cycle, banks free, round-robin -> grants alternate I, D, I, D starting with I after reset. Read returns reach the correct owner in the same order.
- d_addr=0x0002 (bank 1) with m_busy=4'b0010, i_addr=0x0004 (bank 2) -> only i_gnt. d_gnt asserts on the first cycle after m_busy[1] clears.
- m_busy[2] stuck high for 10 cycles while icache waits and dcache streams to bank 0 -> icache is forced to win when bank 2 frees after wait_cnt reaches 7, and d_gnt is suppressed that cycle.
- m_err=1 on the return cycle of a dcache read -> d_err and d_rvalid pulse together; i_err stays 0.
- rst asserted one cycle after an icache read grant -> no i_rvalid and no i_err afterwards; pri_state=PRI_I.
